// File: rtl/sync_fifo_param_if.sv
// Handshake/data bundle for sync_fifo_param.
//   master : producer/consumer side (drives push, din, pop, clear_err)
//   slave  : FIFO side (drives dout, dout_valid, status flags, count, error flags)
// WIDTH and DEPTH must match the values given to the attached FIFO.
interface sync_fifo_param_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             push;
  logic [WIDTH-1:0] din;
  logic             pop;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             clear_err;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, din, pop, clear_err,
    input  dout, dout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  push, din, pop, clear_err,
    output dout, dout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with exact occupancy count, programmable
// almost-full / almost-empty thresholds, a registered read port with a
// one-cycle dout_valid strobe, and sticky overflow/underflow error flags.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-high; clears pointers, count, flags, dout
//   bus    : sync_fifo_param_if.slave (push/din/pop/clear_err in;
//            dout/dout_valid/full/empty/almost_full/almost_empty/count/
//            overflow/underflow out)
module sync_fifo_param #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 16,
  parameter int AFULL_LVL  = 12,
  parameter int AEMPTY_LVL = 4
) (
  input  logic               clk,
  input  logic               reset,
  sync_fifo_param_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_next;
  logic [WIDTH-1:0] dout_r;
  logic             dout_valid_r;
  logic             full_r;
  logic             empty_r;
  logic             afull_r;
  logic             aempty_r;
  logic             overflow_r;
  logic             underflow_r;
  logic             push_ok;
  logic             pop_ok;

  // A push into a full FIFO is still accepted when a pop frees a slot on
  // the same edge; a pop from an empty FIFO is never satisfied by a
  // same-edge push (no bypass path).
  always_comb begin
    pop_ok     = bus.pop & ~empty_r;
    push_ok    = bus.push & (~full_r | pop_ok);
    count_next = count_r;
    if (push_ok && !pop_ok) begin
      count_next = count_r + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_next = count_r - CW'(1);
    end
  end

  // Storage is not reset; writes are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) begin
      mem[wptr] <= bus.din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr         <= '0;
      rptr         <= '0;
      count_r      <= '0;
      dout_r       <= '0;
      dout_valid_r <= 1'b0;
      full_r       <= 1'b0;
      empty_r      <= 1'b1;
      afull_r      <= 1'b0;
      aempty_r     <= 1'b1;
      overflow_r   <= 1'b0;
      underflow_r  <= 1'b0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + AW'(1);
      end
      if (pop_ok) begin
        rptr   <= rptr + AW'(1);
        dout_r <= mem[rptr];
      end
      dout_valid_r <= pop_ok;
      count_r      <= count_next;
      // Flags derive from the next count so they never lag the counter.
      full_r       <= (count_next == CW'(DEPTH));
      empty_r      <= (count_next == '0);
      afull_r      <= (count_next >= CW'(AFULL_LVL));
      aempty_r     <= (count_next <= CW'(AEMPTY_LVL));
      // A new error in the same cycle as clear_err keeps the flag set.
      if (bus.push && !push_ok) begin
        overflow_r <= 1'b1;
      end else if (bus.clear_err) begin
        overflow_r <= 1'b0;
      end
      if (bus.pop && !pop_ok) begin
        underflow_r <= 1'b1;
      end else if (bus.clear_err) begin
        underflow_r <= 1'b0;
      end
    end
  end

  assign bus.dout         = dout_r;
  assign bus.dout_valid   = dout_valid_r;
  assign bus.full         = full_r;
  assign bus.empty        = empty_r;
  assign bus.almost_full  = afull_r;
  assign bus.almost_empty = aempty_r;
  assign bus.count        = count_r;
  assign bus.overflow     = overflow_r;
  assign bus.underflow    = underflow_r;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (WIDTH=16, DEPTH=16, AFULL=12,
// AEMPTY=4). A queue-based reference model is checked after every edge;
// directed tables add hand-written expectations for the corner cases.
module tb_sync_fifo_param;
  localparam int W  = 16;
  localparam int D  = 16;
  localparam int AF = 12;
  localparam int AE = 4;

  logic clk;
  logic reset;

  sync_fifo_param_if #(.WIDTH(W), .DEPTH(D)) bus ();

  sync_fifo_param #(
    .WIDTH(W), .DEPTH(D), .AFULL_LVL(AF), .AEMPTY_LVL(AE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [W-1:0] q[$];
  logic [W-1:0] m_dout;
  logic         m_dv;
  logic         m_ovf;
  logic         m_udf;

  typedef struct {
    logic         push;
    logic [W-1:0] din;
    logic         pop;
    logic         clr;
    int           cnt;
    logic         full;
    logic         empty;
    logic         af;
    logic         ae;
    logic         dv;
    logic [W-1:0] dout;
    logic         ovf;
    logic         udf;
  } vec_t;

  vec_t tab_a[9];
  vec_t tab_b[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_update(input logic p, input logic [W-1:0] d, input logic po,
                              input logic c, input logic r);
    bit pop_ok, push_ok;
    if (r) begin
      q.delete();
      m_dout = '0;
      m_dv   = 1'b0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
      pop_ok  = po && (q.size() != 0);
      push_ok = p && ((q.size() < D) || pop_ok);
      m_dv = pop_ok;
      if (pop_ok) m_dout = q.pop_front();
      if (push_ok) q.push_back(d);
      if (p && !push_ok) m_ovf = 1'b1;
      else if (c) m_ovf = 1'b0;
      if (po && !pop_ok) m_udf = 1'b1;
      else if (c) m_udf = 1'b0;
    end
  endtask

  task automatic model_check();
    int n;
    n = q.size();
    check("count", 32'(bus.count), 32'(n));
    check("full", 32'(bus.full), 32'(n == D));
    check("empty", 32'(bus.empty), 32'(n == 0));
    check("almost_full", 32'(bus.almost_full), 32'(n >= AF));
    check("almost_empty", 32'(bus.almost_empty), 32'(n <= AE));
    check("dout_valid", 32'(bus.dout_valid), 32'(m_dv));
    check("dout", 32'(bus.dout), 32'(m_dout));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
    check("underflow", 32'(bus.underflow), 32'(m_udf));
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled
  // 1 time unit after the next rising edge.
  task automatic step(input logic p, input logic [W-1:0] d, input logic po,
                      input logic c, input logic r);
    bus.push      = p;
    bus.din       = d;
    bus.pop       = po;
    bus.clear_err = c;
    reset         = r;
    @(posedge clk);
    model_update(p, d, po, c, r);
    #1;
    model_check();
  endtask

  task automatic apply_vec(input string tag, input vec_t v);
    step(v.push, v.din, v.pop, v.clr, 1'b0);
    check({tag, " count"}, 32'(bus.count), 32'(v.cnt));
    check({tag, " full"}, 32'(bus.full), 32'(v.full));
    check({tag, " empty"}, 32'(bus.empty), 32'(v.empty));
    check({tag, " afull"}, 32'(bus.almost_full), 32'(v.af));
    check({tag, " aempty"}, 32'(bus.almost_empty), 32'(v.ae));
    check({tag, " dv"}, 32'(bus.dout_valid), 32'(v.dv));
    check({tag, " dout"}, 32'(bus.dout), 32'(v.dout));
    check({tag, " ovf"}, 32'(bus.overflow), 32'(v.ovf));
    check({tag, " udf"}, 32'(bus.underflow), 32'(v.udf));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // push din pop clr | cnt full empty af ae dv dout ovf udf
    tab_a[0] = '{1'b1, 16'hBEEF, 1'b0, 1'b0, 16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tab_a[1] = '{1'b0, 16'h0000, 1'b1, 1'b0, 15, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tab_a[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 14, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0};
    tab_a[3] = '{1'b1, 16'hAAAA, 1'b0, 1'b0, 15, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0};
    tab_a[4] = '{1'b1, 16'hBBBB, 1'b0, 1'b0, 16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0};
    tab_a[5] = '{1'b1, 16'hBEEF, 1'b1, 1'b0, 16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
    tab_a[6] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
    tab_a[7] = '{1'b1, 16'hCCCC, 1'b0, 1'b1, 16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0};
    tab_a[8] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};

    tab_b[0] = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
    tab_b[1] = '{1'b1, 16'h1234, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
    tab_b[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b1};
    tab_b[3] = '{1'b0, 16'h0000, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0};
    tab_b[4] = '{1'b0, 16'h0000, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b1};
    tab_b[5] = '{1'b0, 16'h0000, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0};

    bus.push = 1'b0; bus.din = '0; bus.pop = 1'b0; bus.clear_err = 1'b0; reset = 1'b1;
    #1;

    // Reset state and fill with 0x0000..0x000F
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("reset count", 32'(bus.count), 32'd0);
    check("reset empty", 32'(bus.empty), 32'd1);
    for (int i = 0; i < D; i++) step(1'b1, W'(i), 1'b0, 1'b0, 1'b0);
    check("fill full", 32'(bus.full), 32'd1);

    // Drain in order
    for (int i = 0; i < D; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check("drain order", 32'(bus.dout), 32'(i));
    end
    check("drain empty", 32'(bus.empty), 32'd1);

    // Overflow / full push+pop / clear-vs-set
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < D; i++) step(1'b1, W'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) apply_vec("tab_a", tab_a[i]);
    for (int i = 0; i < D; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("beef last out", 32'(bus.dout), 32'h0000BEEF);

    // Underflow / no bypass / clear
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) apply_vec("tab_b", tab_b[i]);

    // Wrap: alternating bursts of 10 pushes and 7 pops with random data
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int b = 0; b < 40; b++) begin
      if (b % 2 == 0) begin
        for (int i = 0; i < 10; i++) step(1'b1, W'($urandom), 1'b0, 1'b0, 1'b0);
      end else begin
        for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      end
    end

    // Fully random traffic including occasional clear_err and reset
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 99) < 55), W'($urandom), 1'($urandom_range(0, 99) < 50),
           1'($urandom_range(0, 99) < 5), 1'($urandom_range(0, 199) == 0));
    end

    // Reset in the middle of a push burst
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("pre-reset underflow", 32'(bus.underflow), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, W'(16'h5000 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h5003, 1'b0, 1'b0, 1'b1);
    check("mid reset count", 32'(bus.count), 32'd0);
    check("mid reset empty", 32'(bus.empty), 32'd1);
    check("mid reset udf", 32'(bus.underflow), 32'd0);
    check("mid reset ovf", 32'(bus.overflow), 32'd0);
    step(1'b1, 16'h5004, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("post reset pop", 32'(bus.dout), 32'h00005004);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("post reset underflow", 32'(bus.underflow), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
